// File: rtl/div_issue_ctrl.sv
// Issue sequencer between EX and the multi-cycle RV32M divider: latch, launch, watchdog, writeback hold.
// Optional DIV_FASTPATH_EN resolves divide-by-zero and signed overflow without using the divider.
module div_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_ctrl,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  input  logic [REG_AW-1:0] req_rd,
  input  logic              flush,
  output logic              stall,
  output logic              div_start,
  output logic [1:0]        div_ctrl,
  output logic [31:0]       div_numerator,
  output logic [31:0]       div_denominator,
  input  logic [31:0]       div_result,
  input  logic              div_done,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [31:0]       wb_data,
  input  logic              wb_ready,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic [31:0]   wb_data_d;
  logic          timeout_d;
  logic          accept;
  logic          fast_hit;
  logic [31:0]   fast_res;

`ifdef DIV_FASTPATH_EN
  // Architected RV32M results for cases the divider need not see.
  always_comb begin
    fast_hit = 1'b0;
    fast_res = '0;
    if (req_b == 32'd0) begin
      fast_hit = 1'b1;
      fast_res = req_ctrl[1] ? req_a : 32'hFFFF_FFFF;
    end else if (req_a == 32'h8000_0000 && req_b == 32'hFFFF_FFFF) begin
      if (req_ctrl == 2'b00) begin
        fast_hit = 1'b1;
        fast_res = 32'h8000_0000;
      end else if (req_ctrl == 2'b10) begin
        fast_hit = 1'b1;
        fast_res = 32'd0;
      end
    end
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    wb_data_d = wb_data;
    timeout_d = timeout_err;
    accept    = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            accept = 1'b1;
            if (fast_hit) begin
              state_d   = HOLD;
              wb_data_d = fast_res;
            end else begin
              state_d = LAUNCH;
            end
          end
        end
        // div_done may still be high from the previous operation here.
        LAUNCH: begin
          state_d = WAIT;
          wdog_d  = '0;
        end
        WAIT: begin
          if (div_done) begin
            state_d   = HOLD;
            wb_data_d = div_result;
          end else if (wdog_q == CW'(TIMEOUT - 1)) begin
            state_d   = HOLD;
            wb_data_d = '0;
            timeout_d = 1'b1;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
        HOLD: begin
          if (wb_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      wdog_q          <= '0;
      div_ctrl        <= '0;
      div_numerator   <= '0;
      div_denominator <= '0;
      wb_rd           <= '0;
      wb_data         <= '0;
      timeout_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      wb_data     <= wb_data_d;
      timeout_err <= timeout_d;
      if (accept) begin
        div_ctrl        <= req_ctrl;
        div_numerator   <= req_a;
        div_denominator <= req_b;
        wb_rd           <= req_rd;
      end
    end
  end

  assign div_start = (state_q == LAUNCH);
  assign wb_valid  = (state_q == HOLD);
  assign stall     = !rst && (((state_q == IDLE) && req_valid) || (state_q == LAUNCH) ||
                              (state_q == WAIT) || ((state_q == HOLD) && !wb_ready));

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with TIMEOUT = 8; the divider is played by hand-driven div_done/div_result.
module tb_div_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_ctrl;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall, div_start;
  logic [1:0]  div_ctrl;
  logic [31:0] div_numerator, div_denominator, div_result;
  logic        div_done, wb_valid, wb_ready, timeout_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;
  int starts = 0;

  div_issue_ctrl #(.TIMEOUT(8), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ctrl(req_ctrl),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
    .stall(stall), .div_start(div_start), .div_ctrl(div_ctrl),
    .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_result(div_result), .div_done(div_done), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (div_start) starts <= starts + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    req_valid = 1'b1; req_ctrl = op; req_a = a; req_b = b; req_rd = rd;
    #1;
    chk("req_stall", {31'd0, stall}, 32'd1);
    step();
    req_valid = 1'b0; req_a = 32'h5A5A_5A5A; req_b = 32'hA5A5_A5A5; req_rd = 5'd31;
  endtask

  // Assumes the bench sits in WAIT; returns result after 'lat' extra WAIT cycles.
  task automatic finish_div(input int lat, input logic [31:0] res);
    for (int i = 0; i < lat; i++) step();
    div_done = 1'b1; div_result = res;
    step();
    div_done = 1'b0; div_result = 32'hDEAD_BEEF;
  endtask

  task automatic handshake();
    wb_ready = 1'b1;
    #1;
    chk("hs_stall", {31'd0, stall}, 32'd0);
    step();
    wb_ready = 1'b0;
    chk("hs_idle", {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_ctrl = 2'b00; req_a = '0; req_b = '0; req_rd = '0;
    flush = 1'b0; div_result = '0; div_done = 1'b0; wb_ready = 1'b0;
    step(); step();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_start", {31'd0, div_start}, 32'd0);
    chk("rst_wbvalid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_ctrl_ops", {div_ctrl, div_numerator[29:0]}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    step();

    // DIV 10/2, done returned 4 cycles after start
    request(2'b00, 32'd10, 32'd2, 5'd7);
    chk("t1_start", {31'd0, div_start}, 32'd1);
    chk("t1_num", div_numerator, 32'd10);
    chk("t1_den", div_denominator, 32'd2);
    chk("t1_ctrl", {30'd0, div_ctrl}, 32'd0);
    step();
    chk("t1_start_off", {31'd0, div_start}, 32'd0);
    chk("t1_stall_wait", {31'd0, stall}, 32'd1);
    finish_div(3, 32'd5);
    chk("t1_valid", {31'd0, wb_valid}, 32'd1);
    chk("t1_data", wb_data, 32'd5);
    chk("t1_rd", {27'd0, wb_rd}, 32'd7);
    chk("t1_starts", starts, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_hold_valid", {31'd0, wb_valid}, 32'd1);
      chk("t1_hold_data", wb_data, 32'd5);
      chk("t1_hold_stall", {31'd0, stall}, 32'd1);
    end
    chk("t1_num_stable", div_numerator, 32'd10);
    handshake();

    // REMU 0xFFFFFFFF % 256 accepted the cycle after the handshake
    request(2'b11, 32'hFFFF_FFFF, 32'd256, 5'd3);
    chk("t2_start", {31'd0, div_start}, 32'd1);
    chk("t2_ctrl", {30'd0, div_ctrl}, 32'd3);
    step();
    finish_div(0, 32'd255);
    chk("t2_data", wb_data, 32'd255);
    chk("t2_rd", {27'd0, wb_rd}, 32'd3);
    handshake();

    // flush in WAIT, then a late done
    request(2'b00, 32'd20, 32'd4, 5'd9);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_flush_valid", {31'd0, wb_valid}, 32'd0);
    chk("t3_flush_stall", {31'd0, stall}, 32'd0);
    div_done = 1'b1; div_result = 32'd123;
    step();
    div_done = 1'b0;
    chk("t3_late_valid", {31'd0, wb_valid}, 32'd0);
    chk("t3_late_stall", {31'd0, stall}, 32'd0);
    request(2'b01, 32'd100, 32'd7, 5'd4);
    step();
    finish_div(1, 32'd14);
    chk("t3_next_data", wb_data, 32'd14);
    chk("t3_next_rd", {27'd0, wb_rd}, 32'd4);
    handshake();

    // stale done held high across LAUNCH
    div_done = 1'b1; div_result = 32'h0000_DEAD;
    request(2'b00, 32'd9, 32'd3, 5'd2);
    chk("t4_start", {31'd0, div_start}, 32'd1);
    step();
    div_done = 1'b0;
    chk("t4_not_captured", {31'd0, wb_valid}, 32'd0);
    finish_div(1, 32'd3);
    chk("t4_data", wb_data, 32'd3);
    handshake();

    // done arrives on the same edge the watchdog expires
    request(2'b01, 32'd7, 32'd1, 5'd6);
    step();
    finish_div(7, 32'h42);
    chk("t5_tie_data", wb_data, 32'h42);
    chk("t5_tie_tmo", {31'd0, timeout_err}, 32'd0);
    handshake();

    // watchdog expiry with no done
    request(2'b01, 32'd1, 32'd1, 5'd5);
    step();
    for (int i = 0; i < 7; i++) step();
    chk("t6_pre_valid", {31'd0, wb_valid}, 32'd0);
    chk("t6_pre_tmo", {31'd0, timeout_err}, 32'd0);
    step();
    chk("t6_valid", {31'd0, wb_valid}, 32'd1);
    chk("t6_data", wb_data, 32'd0);
    chk("t6_tmo", {31'd0, timeout_err}, 32'd1);
    handshake();
    chk("t6_tmo_sticky", {31'd0, timeout_err}, 32'd1);

    // flush wins over req_valid in IDLE
    req_valid = 1'b1; req_ctrl = 2'b00; req_a = 32'd50; req_b = 32'd5; req_rd = 5'd8;
    flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("t7_no_launch", {31'd0, div_start}, 32'd0);
    chk("t7_no_latch", div_numerator, 32'd1);

    // divide-by-zero cases
    starts = 0;
    request(2'b00, 32'd10, 32'd0, 5'd1);
`ifdef DIV_FASTPATH_EN
    chk("t8_fast_valid", {31'd0, wb_valid}, 32'd1);
`else
    chk("t8_start", {31'd0, div_start}, 32'd1);
    step();
    finish_div(0, 32'hFFFF_FFFF);
`endif
    chk("t8_div0", wb_data, 32'hFFFF_FFFF);
    handshake();
    request(2'b10, 32'd88, 32'd0, 5'd2);
`ifdef DIV_FASTPATH_EN
    chk("t8_fast_valid2", {31'd0, wb_valid}, 32'd1);
    chk("t8_rem0", wb_data, 32'd88);
    handshake();
    request(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
    chk("t8_ovf", wb_data, 32'h8000_0000);
    handshake();
    chk("t8_no_starts", starts, 32'd0);
`else
    chk("t8_start2", {31'd0, div_start}, 32'd1);
    step();
    finish_div(0, 32'd88);
    chk("t8_rem0", wb_data, 32'd88);
    handshake();
    chk("t8_starts", starts, 32'd2);
`endif

    // asynchronous reset mid-operation
    request(2'b00, 32'd30, 32'd3, 5'd11);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t9_rst_stall", {31'd0, stall}, 32'd0);
    chk("t9_rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("t9_rst_tmo", {31'd0, timeout_err}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("t9_idle_stall", {31'd0, stall}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
